// File: rtl/pipelined_alu_fwd.sv
// Four-stage pipelined ALU: register read, execute with operand forwarding,
// register writeback with result/flags, memory store; plus registered memory read-back.
module pipelined_alu_fwd #(
    parameter int unsigned DW = 16,
    parameter int unsigned RN = 4,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [RN-1:0] rs1,
    input  logic [RN-1:0] rs2,
    input  logic [RN-1:0] rd,
    input  logic [3:0]    func,
    input  logic [AW-1:0] addr,
    input  logic          reg_we,
    input  logic          mem_we,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] z,
    output logic          z_valid,
    output logic          zero_flag,
    output logic          carry_flag,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned NREG  = 2 ** RN;
    localparam int unsigned MWORD = 2 ** AW;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b0001;
    localparam logic [3:0] F_MUL  = 4'b0010;
    localparam logic [3:0] F_PA   = 4'b0011;
    localparam logic [3:0] F_PB   = 4'b0100;
    localparam logic [3:0] F_NOTA = 4'b0101;
    localparam logic [3:0] F_NOTB = 4'b0110;
    localparam logic [3:0] F_SHLA = 4'b0111;
    localparam logic [3:0] F_AND  = 4'b1000;
    localparam logic [3:0] F_SHRA = 4'b1001;
    localparam logic [3:0] F_SHLB = 4'b1010;
    localparam logic [3:0] F_OR   = 4'b1011;
    localparam logic [3:0] F_XOR  = 4'b1100;
    localparam logic [3:0] F_SLT  = 4'b1101;

    logic [DW-1:0] regbank [NREG];
    logic [DW-1:0] mem     [MWORD];

    // S1 capture
    logic          s1_valid;
    logic [DW-1:0] s1_a;
    logic [DW-1:0] s1_b;
    logic [RN-1:0] s1_rs1;
    logic [RN-1:0] s1_rs2;
    logic [RN-1:0] s1_rd;
    logic [3:0]    s1_func;
    logic [AW-1:0] s1_addr;
    logic          s1_reg_we;
    logic          s1_mem_we;

    // Execute latch, consumed by regbank writeback and z
    logic          ex_valid;
    logic [DW-1:0] ex_result;
    logic          ex_carry;
    logic          ex_zero;
    logic [RN-1:0] ex_rd;
    logic [AW-1:0] ex_addr;
    logic          ex_reg_we;
    logic          ex_mem_we;

    // Writeback latch, consumed by the memory store
    logic          wb_valid;
    logic [DW-1:0] wb_result;
    logic [RN-1:0] wb_rd;
    logic [AW-1:0] wb_addr;
    logic          wb_reg_we;
    logic          wb_mem_we;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] alu_res;
    logic          alu_carry;

    // Operand forwarding: the execute latch is younger than the writeback latch
    always_comb begin
        op_a = s1_a;
        if (ex_valid && ex_reg_we && (ex_rd == s1_rs1)) begin
            op_a = ex_result;
        end else if (wb_valid && wb_reg_we && (wb_rd == s1_rs1)) begin
            op_a = wb_result;
        end
        op_b = s1_b;
        if (ex_valid && ex_reg_we && (ex_rd == s1_rs2)) begin
            op_b = ex_result;
        end else if (wb_valid && wb_reg_we && (wb_rd == s1_rs2)) begin
            op_b = wb_result;
        end
    end

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (s1_func)
            F_ADD: begin
                alu_res   = sum[DW-1:0];
                alu_carry = sum[DW];
            end
            F_SUB: begin
                alu_res   = diff[DW-1:0];
                alu_carry = diff[DW];
            end
            F_MUL:  alu_res = DW'(op_a * op_b);
            F_PA:   alu_res = op_a;
            F_PB:   alu_res = op_b;
            F_NOTA: alu_res = ~op_a;
            F_NOTB: alu_res = ~op_b;
            F_SHLA: begin
                alu_res   = op_a << 1;
                alu_carry = op_a[DW-1];
            end
            F_AND:  alu_res = op_a & op_b;
            F_SHRA: begin
                alu_res   = op_a >> 1;
                alu_carry = op_a[0];
            end
            F_SHLB: begin
                alu_res   = op_b << 1;
                alu_carry = op_b[DW-1];
            end
            F_OR:   alu_res = op_a | op_b;
            F_XOR:  alu_res = op_a ^ op_b;
            F_SLT:  alu_res = DW'(diff[DW]);
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Pipeline stage registers and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_rd      <= '0;
            s1_func    <= '0;
            s1_addr    <= '0;
            s1_reg_we  <= 1'b0;
            s1_mem_we  <= 1'b0;
            ex_valid   <= 1'b0;
            ex_result  <= '0;
            ex_carry   <= 1'b0;
            ex_zero    <= 1'b0;
            ex_rd      <= '0;
            ex_addr    <= '0;
            ex_reg_we  <= 1'b0;
            ex_mem_we  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_result  <= '0;
            wb_rd      <= '0;
            wb_addr    <= '0;
            wb_reg_we  <= 1'b0;
            wb_mem_we  <= 1'b0;
            z          <= '0;
            z_valid    <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            s1_valid   <= in_valid;
            s1_a       <= regbank[rs1];
            s1_b       <= regbank[rs2];
            s1_rs1     <= rs1;
            s1_rs2     <= rs2;
            s1_rd      <= rd;
            s1_func    <= func;
            s1_addr    <= addr;
            s1_reg_we  <= reg_we;
            s1_mem_we  <= mem_we;

            ex_valid   <= s1_valid;
            ex_result  <= alu_res;
            ex_carry   <= alu_carry;
            ex_zero    <= (alu_res == '0);
            ex_rd      <= s1_rd;
            ex_addr    <= s1_addr;
            ex_reg_we  <= s1_reg_we;
            ex_mem_we  <= s1_mem_we;

            wb_valid   <= ex_valid;
            wb_result  <= ex_result;
            wb_rd      <= ex_rd;
            wb_addr    <= ex_addr;
            wb_reg_we  <= ex_reg_we;
            wb_mem_we  <= ex_mem_we;

            // A bubble holds z but drops valid and both flags
            if (ex_valid) begin
                z <= ex_result;
            end
            z_valid    <= ex_valid;
            zero_flag  <= ex_valid & ex_zero;
            carry_flag <= ex_valid & ex_carry;
        end
    end

    // Register bank: cleared by reset, written from the execute latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regbank[i] <= '0;
            end
        end else if (ex_valid && ex_reg_we) begin
            regbank[ex_rd] <= ex_result;
        end
    end

    // Data memory keeps its contents through reset but never writes during it
    always_ff @(posedge clk) begin
        if (rst_n && wb_valid && wb_mem_we) begin
            mem[wb_addr] <= wb_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
        end
    end

endmodule
